// File: rtl/seq_pkg.sv
// seq_pkg: shared constants for the serial pattern link (state encoding, default pattern)
package seq_pkg;
   localparam int PATTERN_W = 4;
   localparam logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1101;
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_GAP   = 2'b10;
   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_GAP   = ST_GAP
   } tx_state_e;
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: parallel-load shift-left register, MSB is the serial output
//   clk, rst : clock, sync active-high reset
//   load/din : parallel load (has priority over shift)
//   shift    : shift left one place, zero fill
//   sout     : current MSB
module piso_shreg #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             sout
);
   logic [WIDTH-1:0] shreg_q, shreg_d;
   always_comb shreg_d = load ? din : shift ? {shreg_q[WIDTH-2:0], 1'b0} : shreg_q;
   always_ff @(posedge clk) begin
      if (rst) shreg_q <= '0;
      else     shreg_q <= shreg_d;
   end
   assign sout = shreg_q[WIDTH-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter, shifts a word out MSB-first with repeats and gaps
//   clk, rst          : clock, sync active-high reset
//   in_valid/in_ready : word handshake; in_word pattern, in_reps repeat count (0 -> 1)
//   abort             : drop the current transfer
//   dout/dout_valid   : serial bit and its qualifier
//   last              : final bit of final repetition
//   busy              : not idle
module seq_pattern_tx import seq_pkg::*; #(
   parameter int WIDTH = PATTERN_W,
   parameter int REP_W = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_word,
   input  logic [REP_W-1:0] in_reps,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             last,
   output logic             busy
);
   localparam int BW = $clog2(WIDTH);
   localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
   tx_state_e        state_q, state_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [REP_W-1:0] reps_left_q, reps_left_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic [WIDTH-1:0] hold_word_q, hold_word_d;
   logic             accept, word_end, reload, sout;
   // reset holds the handshake closed even though the state already reads IDLE
   assign in_ready = state_q == S_IDLE && !rst;
   assign accept   = in_valid && in_ready;
   assign word_end = state_q == S_SHIFT && bit_cnt_q == '0;
   assign reload   = word_end && reps_left_q > REP_W'(1);
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      reps_left_d = reps_left_q;
      gap_cnt_d   = gap_cnt_q;
      hold_word_d = hold_word_q;
      case (state_q)
         S_IDLE: if (accept) begin
            hold_word_d = in_word;
            bit_cnt_d   = BW'(WIDTH - 1);
            reps_left_d = in_reps == '0 ? REP_W'(1) : in_reps;
            state_d     = S_SHIFT;
         end
         S_SHIFT: begin
            bit_cnt_d = bit_cnt_q - BW'(1);
            if (reload) begin
               reps_left_d = reps_left_q - REP_W'(1);
               bit_cnt_d   = BW'(WIDTH - 1);
               gap_cnt_d   = GW'(GAP - 1);
               state_d     = GAP > 0 ? S_GAP : S_SHIFT;
            end else if (word_end) state_d = S_IDLE;
            if (abort) state_d = S_IDLE;
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            if (gap_cnt_q == '0) state_d = S_SHIFT;
            if (abort) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         reps_left_q <= '0;
         gap_cnt_q   <= '0;
         hold_word_q <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         reps_left_q <= reps_left_d;
         gap_cnt_q   <= gap_cnt_d;
         hold_word_q <= hold_word_d;
      end
   end
   // accept only happens in IDLE, so the two load sources never collide
   piso_shreg #(.WIDTH(WIDTH)) u_piso (
      .clk  (clk),
      .rst  (rst),
      .load (accept || reload),
      .shift(dout_valid),
      .din  (accept ? in_word : hold_word_q),
      .sout (sout)
   );
   assign dout_valid = state_q == S_SHIFT;
   assign dout       = dout_valid && sout;
   assign last       = word_end && reps_left_q == REP_W'(1);
   assign busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench driving a GAP=0 and a GAP=2 transmitter in lockstep
module tb_seq_pattern_tx;
   logic clk = 0, rst = 1, in_valid = 0, abort = 0;
   logic [3:0] in_word = 0, in_reps = 0;
   logic r0, d0, v0, l0, b0, r2, d2, v2, l2, b2;
   int total = 0, bad = 0, cyc = 0, acc = 0;
   typedef struct {logic b; logic l; int c;} exp_t;
   exp_t q0[$], q2[$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   seq_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_word(in_word), .in_reps(in_reps),
      .abort(abort), .dout(d0), .dout_valid(v0), .last(l0), .busy(b0));
   seq_pattern_tx #(.WIDTH(4), .REP_W(4), .GAP(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r2), .in_word(in_word), .in_reps(in_reps),
      .abort(abort), .dout(d2), .dout_valid(v2), .last(l2), .busy(b2));
   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", n, act, exp);
      end
   endtask
   task automatic push(input int d, input logic [3:0] w, input int reps, input int at, input int n);
      exp_t e;
      int g, eff, k;
      g = d == 0 ? 0 : 2;
      eff = reps == 0 ? 1 : reps;
      k = 0;
      for (int r = 0; r < eff; r++)
         for (int i = 0; i < 4; i++) begin
            if (k < n) begin
               e.b = w[3-i];
               e.l = r == eff - 1 && i == 3 && n >= eff * 4;
               e.c = at + r * (4 + g) + i;
               if (d == 0) q0.push_back(e); else q2.push_back(e);
            end
            k++;
         end
   endtask
   task automatic mon(input int d, input logic v, input logic o, input logic l);
      exp_t e;
      if (!v) begin
         if (l) begin
            total++; bad++;
            $display("FAIL last_without_valid u%0d: got last=1 want 0 at cyc %0d", d, cyc);
         end
         return;
      end
      if ((d == 0 ? q0.size() : q2.size()) == 0) begin
         total++; bad++;
         $display("FAIL unexpected_valid u%0d: got dout_valid=1 want 0 at cyc %0d", d, cyc);
         return;
      end
      e = d == 0 ? q0.pop_front() : q2.pop_front();
      chk($sformatf("dout u%0d", d), o, e.b);
      chk($sformatf("last u%0d", d), l, e.l);
      chk($sformatf("bit_cycle u%0d", d), cyc, e.c);
   endtask
   always @(negedge clk) begin
      mon(0, v0, d0, l0);
      mon(2, v2, d2, l2);
   end
   task automatic wait_ready();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (r0 && r2) return;
      end
      total++; bad++;
      $display("FAIL ready_timeout: got in_ready=0 want 1");
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (!b0 && !b2) return;
      end
      total++; bad++;
      $display("FAIL idle_timeout: got busy=1 want 0");
   endtask
   task automatic send(input logic [3:0] w, input int reps, input logic ab);
      wait_ready();
      in_valid = 1; in_word = w; in_reps = 4'(reps); abort = ab;
      @(posedge clk); #1;
      acc = cyc; in_valid = 0; abort = 0;
   endtask
   task automatic goto(input int target);
      do @(negedge clk); while (cyc < target);
   endtask
   task automatic quiet(input string n, input logic rdy);
      chk({n, " ready0"}, r0, rdy); chk({n, " ready2"}, r2, rdy);
      chk({n, " valid0"}, v0, 0);   chk({n, " valid2"}, v2, 0);
      chk({n, " busy0"}, b0, 0);    chk({n, " busy2"}, b2, 0);
      chk({n, " last0"}, l0, 0);    chk({n, " dout0"}, d0, 0);
   endtask
   initial begin
      int t;
      repeat (3) @(negedge clk);
      quiet("reset", 0);
      rst = 0;
      @(negedge clk);
      quiet("post_reset", 1);
      // single word
      send(4'b1101, 1, 0);
      push(0, 4'b1101, 1, acc, 99); push(2, 4'b1101, 1, acc, 99);
      goto(acc + 3);
      chk("t1 ready_on_last", r0, 0);
      chk("t1 busy_on_last", b0, 1);
      @(negedge clk);
      quiet("t1 after_last", 1);
      // three contiguous reps
      send(4'b1101, 3, 0);
      push(0, 4'b1101, 3, acc, 99); push(2, 4'b1101, 3, acc, 99);
      wait_idle();
      // two reps, gap visible on u2 only
      send(4'b1011, 2, 0);
      push(0, 4'b1011, 2, acc, 99); push(2, 4'b1011, 2, acc, 99);
      goto(acc + 4);
      chk("t3 gap_valid2", v2, 0); chk("t3 gap_busy2", b2, 1); chk("t3 gap_ready2", r2, 0);
      wait_idle();
      // zero reps with abort in the accept cycle
      send(4'b0110, 0, 1);
      push(0, 4'b0110, 1, acc, 99); push(2, 4'b0110, 1, acc, 99);
      wait_idle();
      // second word held during a transfer
      send(4'b1101, 1, 0);
      push(0, 4'b1101, 1, acc, 99); push(2, 4'b1101, 1, acc, 99);
      in_valid = 1; in_word = 4'b1111; in_reps = 1;
      t = -1;
      for (int i = 0; i < 20 && t < 0; i++) begin
         @(negedge clk);
         if (r0) t = cyc;
      end
      chk("t5 ready_cycle", t, acc + 4);
      @(posedge clk); #1;
      acc = cyc; in_valid = 0;
      push(0, 4'b1111, 1, acc, 99); push(2, 4'b1111, 1, acc, 99);
      wait_idle();
      // abort in rep 2 bit 2 (u0 SHIFT, u2 GAP)
      send(4'b1011, 3, 0);
      push(0, 4'b1011, 3, acc, 6); push(2, 4'b1011, 3, acc, 4);
      goto(acc + 5);
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      @(negedge clk);
      quiet("t6 abort", 1);
      // reset while u2 sits in GAP
      send(4'b1011, 2, 0);
      push(0, 4'b1011, 2, acc, 5); push(2, 4'b1011, 2, acc, 4);
      goto(acc + 4);
      rst = 1;
      @(negedge clk);
      quiet("t6 in_reset", 0);
      rst = 0;
      @(negedge clk);
      quiet("t6 after_reset", 1);
      repeat (3) @(negedge clk);
      chk("drain q0", q0.size(), 0);
      chk("drain q2", q2.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
